// File: rtl/multicycle_shift_ctrl.sv
// Iterative shifter for SLL/SRL/SRA. One request at a time: the operand is
// stepped through a 2-bit shift stage, with a final 1-bit step for odd amounts.
// Valid/ready on both sides; busy stalls the surrounding pipeline.
module multicycle_shift_ctrl #(
    parameter int N       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // SHIFT | stepping acc by 2 (or 1 on the last odd step) until rem is 0
    // DONE  | result presented on out_data, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state;
    state_t             state_next;
    logic [N-1:0]       acc;
    logic [N-1:0]       acc_step;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] rem_step;
    logic [1:0]         op;
    logic               step_two;

    // One shift step: 2 bits while at least 2 remain, else the final single bit.
    // Amounts beyond N saturate naturally because every step keeps shifting.
    always_comb begin
        step_two = (rem >= SHAMT_W'(2));
        rem_step = step_two ? (rem - SHAMT_W'(2)) : '0;
        case (op)
            OP_SRL:  acc_step = step_two ? (acc >> 2) : (acc >> 1);
            OP_SRA:  acc_step = step_two ? $unsigned($signed(acc) >>> 2)
                                         : $unsigned($signed(acc) >>> 1);
            default: acc_step = step_two ? (acc << 2) : (acc << 1);
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_step == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands are captured only on accept, then acc/rem step in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            rem <= '0;
            op  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= in_data;
                        rem <= in_shamt;
                        op  <= in_op;
                    end
                end
                SHIFT: begin
                    acc <= acc_step;
                    rem <= rem_step;
                end
                default: begin
                    acc <= acc;
                    rem <= rem;
                    op  <= op;
                end
            endcase
        end
    end

    // Outputs decoded from state; out_data is only driven with acc in DONE.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = (state == DONE) ? acc : '0;
    end

endmodule

// File: tb/tb_multicycle_shift_ctrl.sv
// Scoreboard bench for multicycle_shift_ctrl: the stimulus pushes expected
// results from a plain-arithmetic reference model, a monitor pops and compares.
module tb_multicycle_shift_ctrl;

    localparam int N       = 32;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;
    logic               busy;

    multicycle_shift_ctrl #(.N(N), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stall_left = 0;
    bit   rand_ready = 1'b0;
    bit   seen = 1'b0;
    logic [N-1:0] held;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the whole shift done at once, reserved op behaves as SLL.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int s, input logic [1:0] o);
        logic signed [N-1:0] sd;
        sd = d;
        if (o == 2'b01) return (s >= N) ? '0 : (d >> s);
        if (o == 2'b10) return (s >= N) ? {N{d[N-1]}} : $unsigned(sd >>> s);
        return (s >= N) ? '0 : (d << s);
    endfunction

    // Latency counted in edges, with the accept edge itself as cycle 1.
    function automatic int ref_lat(input int s);
        return 1 + (s + 1) / 2;
    endfunction

    // Consumer: holds out_ready low for stall_left valid cycles, else 1 or random.
    always @(posedge clk) begin
        #1;
        if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left = stall_left - 1;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: compares each presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_data), 64'hDEAD_0000_0000);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 64'(out_data), 64'(e.data));
                    check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                end
                seen = 1'b1;
                held = out_data;
            end else begin
                check("hold_data", 64'(out_data), 64'(held));
            end
            if (out_ready) seen = 1'b0;
        end
    end

    // Presents one request and holds it until accepted; returns at the next negedge.
    task automatic issue(input logic [N-1:0] d, input int s, input logic [1:0] o);
        int waited;
        exp_t e;
        in_data  = d;
        in_shamt = s[SHAMT_W-1:0];
        in_op    = o;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            check("accept_timeout", 64'(waited), 64'd0);
        end else begin
            e.data    = ref_shift(d, s, o);
            e.lat     = ref_lat(s);
            e.acc_cyc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SHAMT_W'($urandom);
        in_op    = 2'($urandom);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 64'(waited >= 2000), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready_held", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Reset in the middle of a long SLL: result must never appear.
        issue(32'h0000_00FF, 20, 2'b00);
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        void'(exp_q.pop_back());
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed cases.
        issue(32'h0000_0001, 4, 2'b00);
        issue(32'h8000_0000, 31, 2'b10);
        issue(32'h8000_0000, 31, 2'b01);
        issue(32'hF0F0_F0F0, 0, 2'b01);
        issue(32'h8765_4321, 7, 2'b11);
        drain();
        stall_left = 5;
        issue(32'h1234_5678, 3, 2'b00);
        check("busy_in_ready", 64'(in_ready), 64'd0);
        drain();
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Randomized back-to-back traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap == 3) repeat ($urandom_range(1, 4)) @(negedge clk);
            issue($urandom, $urandom_range(0, 31), 2'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: cycle %0d, expected completion", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
